// File: rtl/digital_lock_pkg.sv
// Shared types and width helpers for the sequential digital lock.
// Default parameter values live here so the top, interface and bench agree.
package digital_lock_pkg;

   typedef enum logic [1:0] {
      ENTER    = 2'd0,
      UNLOCKED = 2'd1,
      PROGRAM  = 2'd2,
      LOCKOUT  = 2'd3
   } lock_state_e;

   localparam int DEF_DIGIT_W     = 4;
   localparam int DEF_CODE_LEN    = 4;
   localparam int DEF_MAX_TRIES   = 3;
   localparam int DEF_LOCKOUT_CYC = 16;
   localparam int CODE_W          = DEF_CODE_LEN * DEF_DIGIT_W;

   function automatic int cnt_width(input int code_len);
      return $clog2(code_len + 1);
   endfunction

   function automatic int tries_width(input int max_tries);
      return $clog2(max_tries + 1);
   endfunction

   // Timer holds LOCKOUT_CYC-1 down to 0; keep at least one bit for LOCKOUT_CYC==1.
   function automatic int timer_width(input int cyc);
      return (cyc > 1) ? $clog2(cyc) : 1;
   endfunction

   localparam int CNT_W   = cnt_width(DEF_CODE_LEN);
   localparam int TRIES_W = tries_width(DEF_MAX_TRIES);
   localparam int TIMER_W = timer_width(DEF_LOCKOUT_CYC);

endpackage

// File: rtl/digital_lock_if.sv
// Keypad-side inputs and actuator/alarm-side outputs of the digital lock.
// master = keypad/controller side, slave = the lock itself.
interface digital_lock_if
   import digital_lock_pkg::*;
#(
   parameter int DIGIT_W   = DEF_DIGIT_W,
   parameter int CODE_LEN  = DEF_CODE_LEN,
   parameter int MAX_TRIES = DEF_MAX_TRIES
);
   logic                                digit_valid;
   logic [DIGIT_W-1:0]                  digit;
   logic                                clear;
   logic                                lock_req;
   logic                                set_code_req;
   logic                                unlocked;
   logic                                alarm;
   logic                                pass_pulse;
   logic                                fail_pulse;
   logic                                prog_done;
   logic [cnt_width(CODE_LEN)-1:0]      entry_cnt;
   logic [tries_width(MAX_TRIES)-1:0]   tries_left;

   modport master (
      output digit_valid, digit, clear, lock_req, set_code_req,
      input  unlocked, alarm, pass_pulse, fail_pulse, prog_done, entry_cnt, tries_left
   );

   modport slave (
      input  digit_valid, digit, clear, lock_req, set_code_req,
      output unlocked, alarm, pass_pulse, fail_pulse, prog_done, entry_cnt, tries_left
   );
endinterface

// File: rtl/digital_lock_code_cmp.sv
// Parametrised equality comparator; generalises the old fixed 4-bit compare.
// Purely combinational, eq and neq are always complementary.
module code_cmp #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             neq
);
   logic [WIDTH-1:0] diff;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign diff[gi] = a[gi] ^ b[gi];
   end

   assign eq  = ~|diff;
   assign neq = |diff;
endmodule

// File: rtl/digital_lock_fsm.sv
// Sequential keypad lock: collects CODE_LEN digits, compares against a
// reprogrammable code, counts failures and enforces a timed alarm lockout.
module digital_lock_fsm
   import digital_lock_pkg::*;
#(
   parameter int                              DIGIT_W      = DEF_DIGIT_W,
   parameter int                              CODE_LEN     = DEF_CODE_LEN,
   parameter int                              MAX_TRIES    = DEF_MAX_TRIES,
   parameter int                              LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
   parameter logic [CODE_LEN*DIGIT_W-1:0]     DEFAULT_CODE = 16'hD5A3
) (
   input  logic          clk,
   input  logic          rst,
   digital_lock_if.slave bus
);
   localparam int CW      = CODE_LEN * DIGIT_W;
   localparam int C_W     = cnt_width(CODE_LEN);
   localparam int T_W     = tries_width(MAX_TRIES);
   localparam int TM_W    = timer_width(LOCKOUT_CYC);

   localparam logic [C_W-1:0]  LAST_IDX   = C_W'(CODE_LEN - 1);
   localparam logic [T_W-1:0]  TRIES_INIT = T_W'(MAX_TRIES);
   localparam logic [TM_W-1:0] TIMER_INIT = TM_W'(LOCKOUT_CYC - 1);

   lock_state_e      state_reg,    state_next;
   logic [CW-1:0]    code_reg,     code_next;
   logic [CW-1:0]    shift_reg,    shift_next;
   logic [C_W-1:0]   cnt_reg,      cnt_next;
   logic [T_W-1:0]   tries_reg,    tries_next;
   logic [TM_W-1:0]  timer_reg,    timer_next;
   logic             unlocked_reg, unlocked_next;
   logic             alarm_reg,    alarm_next;
   logic             pass_reg,     pass_next;
   logic             fail_reg,     fail_next;
   logic             prog_reg,     prog_next;

   logic [CW-1:0]    candidate;
   logic             code_match;
   logic             code_mismatch;

   // Oldest digit falls off the MS end; the final digit completes a full code word.
   assign candidate = CW'({shift_reg, bus.digit});

   code_cmp #(.WIDTH(CW)) u_cmp (
      .a   (candidate),
      .b   (code_reg),
      .eq  (code_match),
      .neq (code_mismatch)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ENTER;
         code_reg     <= DEFAULT_CODE;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         tries_reg    <= TRIES_INIT;
         timer_reg    <= '0;
         unlocked_reg <= 1'b0;
         alarm_reg    <= 1'b0;
         pass_reg     <= 1'b0;
         fail_reg     <= 1'b0;
         prog_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         code_reg     <= code_next;
         shift_reg    <= shift_next;
         cnt_reg      <= cnt_next;
         tries_reg    <= tries_next;
         timer_reg    <= timer_next;
         unlocked_reg <= unlocked_next;
         alarm_reg    <= alarm_next;
         pass_reg     <= pass_next;
         fail_reg     <= fail_next;
         prog_reg     <= prog_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      code_next     = code_reg;
      shift_next    = shift_reg;
      cnt_next      = cnt_reg;
      tries_next    = tries_reg;
      timer_next    = timer_reg;
      unlocked_next = unlocked_reg;
      alarm_next    = alarm_reg;
      pass_next     = 1'b0;
      fail_next     = 1'b0;
      prog_next     = 1'b0;

      case (state_reg)
         ENTER: begin
            if (bus.clear) begin
               cnt_next   = '0;
               shift_next = '0;
            end else if (bus.digit_valid) begin
               if (cnt_reg == LAST_IDX) begin
                  cnt_next   = '0;
                  shift_next = '0;
                  if (code_match) begin
                     state_next    = UNLOCKED;
                     unlocked_next = 1'b1;
                     pass_next     = 1'b1;
                     tries_next    = TRIES_INIT;
                  end
                  if (code_mismatch) begin
                     fail_next = 1'b1;
                     if (tries_reg > T_W'(1)) begin
                        tries_next = tries_reg - T_W'(1);
                     end else begin
                        state_next = LOCKOUT;
                        alarm_next = 1'b1;
                        timer_next = TIMER_INIT;
                        tries_next = '0;
                     end
                  end
               end else begin
                  shift_next = candidate;
                  cnt_next   = cnt_reg + C_W'(1);
               end
            end
         end

         UNLOCKED: begin
            if (bus.lock_req) begin
               state_next    = ENTER;
               unlocked_next = 1'b0;
            end else if (bus.set_code_req) begin
               state_next = PROGRAM;
               cnt_next   = '0;
               shift_next = '0;
            end
         end

         PROGRAM: begin
            if (bus.lock_req) begin
               state_next    = ENTER;
               unlocked_next = 1'b0;
               cnt_next      = '0;
               shift_next    = '0;
            end else if (bus.clear) begin
               state_next = UNLOCKED;
               cnt_next   = '0;
               shift_next = '0;
            end else if (bus.digit_valid) begin
               if (cnt_reg == LAST_IDX) begin
                  code_next  = candidate;
                  prog_next  = 1'b1;
                  state_next = UNLOCKED;
                  cnt_next   = '0;
                  shift_next = '0;
               end else begin
                  shift_next = candidate;
                  cnt_next   = cnt_reg + C_W'(1);
               end
            end
         end

         LOCKOUT: begin
            if (timer_reg == '0) begin
               state_next = ENTER;
               alarm_next = 1'b0;
               tries_next = TRIES_INIT;
            end else begin
               timer_next = timer_reg - TM_W'(1);
            end
         end

         default: state_next = ENTER;
      endcase
   end

   assign bus.unlocked   = unlocked_reg;
   assign bus.alarm      = alarm_reg;
   assign bus.pass_pulse = pass_reg;
   assign bus.fail_pulse = fail_reg;
   assign bus.prog_done  = prog_reg;
   assign bus.entry_cnt  = cnt_reg;
   assign bus.tries_left = tries_reg;
endmodule

// File: tb/tb_digital_lock_fsm.sv
// Self-checking bench for digital_lock_fsm: table of single-cycle vectors plus
// hand-written multi-cycle sequences, expectations queued and popped per cycle.
module tb_digital_lock_fsm;

   typedef struct packed {
      logic       unl;
      logic       alm;
      logic       pas;
      logic       fal;
      logic       prg;
      logic [2:0] cnt;
      logic [1:0] trl;
   } obs_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       dv;
      logic [3:0] d;
      logic       clr;
      logic       lk;
      logic       sc;
      obs_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   obs_t  exp_q[$];
   string name_q[$];
   vec_t  tbl[$];

   digital_lock_if #(.DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(3)) bus ();

   digital_lock_fsm #(
      .DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(3), .LOCKOUT_CYC(16), .DEFAULT_CODE(16'hD5A3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t o(input logic unl, alm, pas, fal, prg,
                              input logic [2:0] cnt, input logic [1:0] trl);
      obs_t r;
      r = '{unl: unl, alm: alm, pas: pas, fal: fal, prg: prg, cnt: cnt, trl: trl};
      return r;
   endfunction

   function automatic vec_t mk(input string n, input logic r, dv, input logic [3:0] d,
                               input logic clr, lk, sc, input obs_t e);
      vec_t v;
      v = '{name: n, rst: r, dv: dv, d: d, clr: clr, lk: lk, sc: sc, exp: e};
      return v;
   endfunction

   task automatic check_out();
      obs_t  got;
      obs_t  want;
      string n;
      got  = '{unl: bus.unlocked, alm: bus.alarm, pas: bus.pass_pulse, fal: bus.fail_pulse,
               prg: bus.prog_done, cnt: bus.entry_cnt, trl: bus.tries_left};
      want = exp_q.pop_front();
      n    = name_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got unl/alm/pas/fal/prg/cnt/trl=%b required=%b", n, got, want);
      end else begin
         $display("step %s out=%b", n, got);
      end
   endtask

   task automatic drive(input vec_t v);
      rst              = v.rst;
      bus.digit_valid  = v.dv;
      bus.digit        = v.d;
      bus.clear        = v.clr;
      bus.lock_req     = v.lk;
      bus.set_code_req = v.sc;
      exp_q.push_back(v.exp);
      name_q.push_back(v.name);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic cyc(input string n, input logic r, dv, input logic [3:0] d,
                      input logic clr, lk, sc, input obs_t e);
      drive(mk(n, r, dv, d, clr, lk, sc, e));
   endtask

   // Four-digit entry: intermediate digits keep unl/trl and count up, last one checks fin.
   task automatic entry4(input string n, input logic [15:0] code, input logic unl,
                         input logic [1:0] trl, input obs_t fin);
      logic [3:0] dg;
      for (int i = 0; i < 4; i++) begin
         dg = code[15-4*i -: 4];
         if (i < 3)
            cyc($sformatf("%s_d%0d", n, i), 0, 1, dg, 0, 0, 0,
                o(unl, 0, 0, 0, 0, 3'(i + 1), trl));
         else
            cyc($sformatf("%s_d%0d", n, i), 0, 1, dg, 0, 0, 0, fin);
      end
   endtask

   initial begin
      bus.digit_valid  = 1'b0;
      bus.digit        = 4'h0;
      bus.clear        = 1'b0;
      bus.lock_req     = 1'b0;
      bus.set_code_req = 1'b0;

      // Table: reset, default-code unlock, UNLOCKED behaviour, clear handling.
      tbl.push_back(mk("rst0",      1, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3)));
      tbl.push_back(mk("rst1",      1, 1, 4'hD, 0, 0, 0, o(0,0,0,0,0,0,3)));
      tbl.push_back(mk("pD",        0, 1, 4'hD, 0, 0, 0, o(0,0,0,0,0,1,3)));
      tbl.push_back(mk("p5",        0, 1, 4'h5, 0, 0, 0, o(0,0,0,0,0,2,3)));
      tbl.push_back(mk("pA",        0, 1, 4'hA, 0, 0, 0, o(0,0,0,0,0,3,3)));
      tbl.push_back(mk("p3_pass",   0, 1, 4'h3, 0, 0, 0, o(1,0,1,0,0,0,3)));
      tbl.push_back(mk("unl_hold",  0, 0, 4'h0, 0, 0, 0, o(1,0,0,0,0,0,3)));
      tbl.push_back(mk("unl_dig",   0, 1, 4'h7, 1, 0, 0, o(1,0,0,0,0,0,3)));
      tbl.push_back(mk("lk_prio",   0, 0, 4'h0, 0, 1, 1, o(0,0,0,0,0,0,3)));
      tbl.push_back(mk("cD",        0, 1, 4'hD, 0, 0, 0, o(0,0,0,0,0,1,3)));
      tbl.push_back(mk("c5",        0, 1, 4'h5, 0, 0, 0, o(0,0,0,0,0,2,3)));
      tbl.push_back(mk("clr_win",   0, 1, 4'hA, 1, 0, 0, o(0,0,0,0,0,0,3)));
      tbl.push_back(mk("c2D",       0, 1, 4'hD, 0, 0, 0, o(0,0,0,0,0,1,3)));
      tbl.push_back(mk("c25",       0, 1, 4'h5, 0, 0, 0, o(0,0,0,0,0,2,3)));
      tbl.push_back(mk("c2A",       0, 1, 4'hA, 0, 0, 0, o(0,0,0,0,0,3,3)));
      tbl.push_back(mk("c23_pass",  0, 1, 4'h3, 0, 0, 0, o(1,0,1,0,0,0,3)));
      tbl.push_back(mk("relock",    0, 0, 4'h0, 0, 1, 0, o(0,0,0,0,0,0,3)));
      tbl.push_back(mk("ent_idle",  0, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3)));
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

      // Three wrong entries, then a 16-cycle alarm that ignores all inputs.
      entry4("bad1", 16'h1234, 0, 3, o(0,0,0,1,0,0,2));
      entry4("bad2", 16'h1234, 0, 2, o(0,0,0,1,0,0,1));
      entry4("bad3", 16'h1234, 0, 1, o(0,1,0,1,0,0,0));
      for (int k = 0; k < 15; k++) begin
         logic [15:0] good;
         logic [3:0]  dg;
         good = 16'hD5A3;
         dg   = (k < 4) ? good[15-4*k -: 4] : 4'h0;
         cyc($sformatf("lock_%0d", k), 0, (k < 4), dg, (k == 5), (k == 6), (k == 7),
             o(0,1,0,0,0,0,0));
      end
      cyc("lock_end", 0, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3));

      // Reprogram to 7701, then check old and new codes.
      entry4("unl_a", 16'hD5A3, 0, 3, o(1,0,1,0,0,0,3));
      cyc("setc", 0, 0, 4'h0, 0, 0, 1, o(1,0,0,0,0,0,3));
      entry4("prog", 16'h7701, 1, 3, o(1,0,0,0,1,0,3));
      cyc("prog_lk", 0, 0, 4'h0, 0, 1, 0, o(0,0,0,0,0,0,3));
      entry4("old_bad", 16'hD5A3, 0, 3, o(0,0,0,1,0,0,2));
      entry4("new_ok", 16'h7701, 0, 2, o(1,0,1,0,0,0,3));

      // Aborts inside PROGRAM leave the code unchanged.
      cyc("setc2", 0, 0, 4'h0, 0, 0, 1, o(1,0,0,0,0,0,3));
      cyc("ab7a",  0, 1, 4'h7, 0, 0, 0, o(1,0,0,0,0,1,3));
      cyc("ab7b",  0, 1, 4'h7, 0, 0, 0, o(1,0,0,0,0,2,3));
      cyc("ab_lk", 0, 1, 4'h0, 1, 1, 0, o(0,0,0,0,0,0,3));
      entry4("keep1", 16'h7701, 0, 3, o(1,0,1,0,0,0,3));
      cyc("setc3", 0, 0, 4'h0, 0, 0, 1, o(1,0,0,0,0,0,3));
      cyc("ab9",   0, 1, 4'h9, 0, 0, 0, o(1,0,0,0,0,1,3));
      cyc("ab_clr",0, 1, 4'h9, 1, 0, 0, o(1,0,0,0,0,0,3));
      cyc("relk2", 0, 0, 4'h0, 0, 1, 0, o(0,0,0,0,0,0,3));
      entry4("keep2", 16'h7701, 0, 3, o(1,0,1,0,0,0,3));

      // Reset after reprogramming restores the default code.
      cyc("rst_prog", 1, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3));
      entry4("post_rst_bad", 16'h7701, 0, 3, o(0,0,0,1,0,0,2));
      entry4("post_rst_ok",  16'hD5A3, 0, 2, o(1,0,1,0,0,0,3));

      // Reset in the middle of a lockout.
      cyc("relk3", 0, 0, 4'h0, 0, 1, 0, o(0,0,0,0,0,0,3));
      entry4("lb1", 16'h0000, 0, 3, o(0,0,0,1,0,0,2));
      entry4("lb2", 16'hFFFF, 0, 2, o(0,0,0,1,0,0,1));
      entry4("lb3", 16'hD5A2, 0, 1, o(0,1,0,1,0,0,0));
      for (int k = 0; k < 4; k++)
         cyc($sformatf("lb_wait%0d", k), 0, 0, 4'h0, 0, 0, 0, o(0,1,0,0,0,0,0));
      cyc("rst_lock", 1, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3));
      cyc("after_rst", 0, 0, 4'h0, 0, 0, 0, o(0,0,0,0,0,0,3));
      entry4("final_ok", 16'hD5A3, 0, 3, o(1,0,1,0,0,0,3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
